// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// serialiser states and elaboration-time helpers.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Clocks per line bit; a zero baud yields 0 so the range check can reject it.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return (baud == 0) ? 0 : clk_hz / baud;
    endfunction

    function automatic int unsigned uart_frame_len(input int unsigned data_bits,
                                                   input int unsigned parity,
                                                   input int unsigned stop_bits,
                                                   input int unsigned div);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * div;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; DEPTH is a power of two
// so pointers wrap naturally.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: contents are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: valid/ready input FIFO feeding a frame
// serialiser that sends queued words back-to-back with no idle gap.
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned DIV   = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = 4;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo_param: CLK_FREQ_HZ / BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_state_e            state_q, state_d;
    logic [CNT_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   load_c;
    logic                   bit_end_c;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign in_ready = !fifo_full;
    assign tx       = tx_q;
    assign tx_busy  = (state_q != ST_IDLE) || (fifo_level != '0);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid && in_ready),
        .din   (in_data),
        .pop   (load_c),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state: each bit lasts DIV clocks; bit_q counts data bits, then stop bits.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        load_c    = 1'b0;
        bit_end_c = (baud_q == CNT_W'(DIV - 1));

        if (state_q != ST_IDLE) begin
            baud_d = bit_end_c ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                load_c = !fifo_empty;
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        load_c  = !fifo_empty;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start, from IDLE or straight out of the last stop clock.
        if (load_c) begin
            state_d = ST_START;
            shift_d = fifo_dout;
            par_d   = (^fifo_dout) ^ 1'(PARITY == PAR_ODD);
            tx_d    = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: three configurations (8N1, 8E1, 7O2, DIV=10)
// with a queue scoreboard and per-line monitors that decode every tx sample.
module tb_uart_tx_fifo_param;

    localparam int DIV = 10;

    int db_c  [3];
    int par_c [3];
    int sb_c  [3];

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] din_v   [3];
    logic       valid_v [3];
    logic       ready_v [3];
    logic       tx_v    [3];
    logic       busy_v  [3];
    logic [2:0] lvl_v   [3];

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q   [3][$];
    int         start_q [3][$];
    int         frames  [3];
    int         acc_cyc [3];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_tx_fifo_param #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8n1 (
        .clock(clock), .reset(reset), .in_data(din_v[0][7:0]), .in_valid(valid_v[0]),
        .in_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .fifo_level(lvl_v[0])
    );

    uart_tx_fifo_param #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_8e1 (
        .clock(clock), .reset(reset), .in_data(din_v[1][7:0]), .in_valid(valid_v[1]),
        .in_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .fifo_level(lvl_v[1])
    );

    uart_tx_fifo_param #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_7o2 (
        .clock(clock), .reset(reset), .in_data(din_v[2][6:0]), .in_valid(valid_v[2]),
        .in_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .fifo_level(lvl_v[2])
    );

    function automatic int frame_len(input int l);
        return (1 + db_c[l] + ((par_c[l] != 0) ? 1 : 0) + sb_c[l]) * DIV;
    endfunction

    // Line bit k of the frame carrying word w: start, data LSB first, parity, stops.
    function automatic logic exp_bit(input int l, input logic [8:0] w, input int k);
        int ones;
        ones = 0;
        if (k == 0) return 1'b0;
        if (k <= db_c[l]) return w[k-1];
        if (par_c[l] != 0 && k == db_c[l] + 1) begin
            for (int i = 0; i < db_c[l]; i++) ones += int'(w[i]);
            return (par_c[l] == 1) ? 1'((ones % 2) == 1) : 1'((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called on the first low sample; compares every clock of the frame.
    task automatic watch_frame(input int l);
        int         total;
        int         bad;
        logic       got;
        logic       want;
        logic [8:0] w;
        bit         aborted;
        total   = frame_len(l);
        bad     = -1;
        got     = 1'b0;
        want    = 1'b0;
        aborted = 1'b0;
        frames[l]++;
        start_q[l].push_back(cyc);
        if (exp_q[l].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_unexpected lane %0d: start bit seen at cycle %0d, none expected", l, cyc);
            repeat (total - 1) @(negedge clock);
            return;
        end
        w = exp_q[l].pop_front();
        for (int s = 0; s < total; s++) begin
            if (s > 0) @(negedge clock);
            if (reset) begin
                aborted = 1'b1;
                break;
            end
            if (bad < 0 && tx_v[l] !== exp_bit(l, w, s / DIV)) begin
                bad  = s;
                got  = tx_v[l];
                want = exp_bit(l, w, s / DIV);
            end
        end
        if (!aborted) begin
            n_cmp++;
            if (bad >= 0) begin
                n_bad++;
                $display("FAIL frame lane %0d word 0x%0h: clock %0d of frame tx=%0b, expected %0b",
                         l, w, bad, got, want);
            end
        end
    endtask

    task automatic monitor(input int l);
        forever begin
            @(negedge clock);
            if (!reset && tx_v[l] === 1'b0) watch_frame(l);
        end
    endtask

    // Call at a negedge; returns at the negedge after acceptance with valid still high.
    task automatic send(input int l, input logic [8:0] w);
        logic r;
        int   n;
        n          = 0;
        din_v[l]   = w;
        valid_v[l] = 1'b1;
        forever begin
            r = ready_v[l];
            @(posedge clock);
            if (r) begin
                exp_q[l].push_back(w);
                break;
            end
            @(negedge clock);
            n++;
            if (n > 1000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout lane %0d: in_ready stayed 0, expected 1 within 1000 clocks", l);
                break;
            end
        end
        @(negedge clock);
        acc_cyc[l] = cyc;
    endtask

    task automatic wait_idle(input int l);
        int n;
        n = 0;
        while (busy_v[l] !== 1'b0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout lane %0d: tx_busy=%0b, expected 0", l, busy_v[l]);
        end
        repeat (2) @(negedge clock);
    endtask

    // One word: start latency, tx_busy span and decoded frame.
    task automatic single(input int l, input logic [8:0] w);
        int n;
        start_q[l].delete();
        send(l, w);
        valid_v[l] = 1'b0;
        n = 0;
        while (busy_v[l] === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check($sformatf("busy_span_l%0d", l), n, frame_len(l) + 1);
        check($sformatf("start_count_l%0d", l), start_q[l].size(), 1);
        if (start_q[l].size() == 1)
            check($sformatf("start_latency_l%0d", l), start_q[l][0] - acc_cyc[l], 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic rand_lane(input int l);
        int         gap;
        logic [8:0] w;
        for (int k = 0; k < 12; k++) begin
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 150)) : 0;
            if (gap > 0) begin
                valid_v[l] = 1'b0;
                repeat (gap) @(negedge clock);
            end
            w = 9'($urandom) & 9'((1 << db_c[l]) - 1);
            send(l, w);
        end
        valid_v[l] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1);
    end

    initial begin
        int a0;
        int fr;
        db_c  = '{8, 8, 7};
        par_c = '{0, 1, 2};
        sb_c  = '{1, 1, 2};
        for (int l = 0; l < 3; l++) begin
            din_v[l]   = '0;
            valid_v[l] = 1'b0;
            frames[l]  = 0;
            acc_cyc[l] = 0;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int l = 0; l < 3; l++) begin
            check($sformatf("rst_tx_l%0d", l), int'(tx_v[l]), 1);
            check($sformatf("rst_busy_l%0d", l), int'(busy_v[l]), 0);
            check($sformatf("rst_ready_l%0d", l), int'(ready_v[l]), 1);
            check($sformatf("rst_level_l%0d", l), int'(lvl_v[l]), 0);
        end
        reset = 1'b0;
        @(negedge clock);

        single(0, 9'h055);
        single(1, 9'h007);
        single(2, 9'h007);
        single(2, 9'h041);

        // Back-to-back frames: second start immediately follows the first stop.
        start_q[0].delete();
        send(0, 9'h0A5);
        send(0, 9'h03C);
        valid_v[0] = 1'b0;
        wait_idle(0);
        check("b2b_frames", start_q[0].size(), 2);
        if (start_q[0].size() == 2)
            check("b2b_gap", start_q[0][1] - start_q[0][0], frame_len(0));

        // Fill to depth with valid held, then the sixth word waits for a pop.
        for (int l = 0; l < 3; l++) begin
            send(l, 9'h011);
            a0 = acc_cyc[l];
            for (int k = 1; k < 5; k++) send(l, 9'(k * 9 + 3));
            check($sformatf("full_level_l%0d", l), int'(lvl_v[l]), 4);
            check($sformatf("full_ready_l%0d", l), int'(ready_v[l]), 0);
            send(l, 9'h05A);
            check($sformatf("word5_accept_l%0d", l), acc_cyc[l] - a0, frame_len(l) + 2);
            valid_v[l] = 1'b0;
            wait_idle(l);
        end

        // Reset 35 clocks into a frame with two words queued.
        send(0, 9'h0F0);
        a0 = acc_cyc[0];
        send(0, 9'h00F);
        send(0, 9'h0C3);
        valid_v[0] = 1'b0;
        while (cyc < a0 + 1 + 35) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_tx", int'(tx_v[0]), 1);
        check("midrst_level", int'(lvl_v[0]), 0);
        check("midrst_busy", int'(busy_v[0]), 0);
        check("midrst_ready", int'(ready_v[0]), 1);
        reset = 1'b0;
        exp_q[0].delete();
        fr = frames[0];
        repeat (300) @(negedge clock);
        check("midrst_no_frames", frames[0], fr);
        check("midrst_tx_idle", int'(tx_v[0]), 1);

        // Randomised traffic on all three lines at once.
        fork
            rand_lane(0);
            rand_lane(1);
            rand_lane(2);
        join
        for (int l = 0; l < 3; l++) wait_idle(l);
        for (int l = 0; l < 3; l++)
            check($sformatf("drained_l%0d", l), exp_q[l].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
